mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Parametrised pipeline Memory stage sitting between Execute and Writeback.
- Registers the E→M pipeline fields, including its own copy of the memory-control fields.
- Drives a valid/ready request bus with byte enables and a response channel, and supports sub-word loads and stores (B/H/W, plus D when XLEN=64) with sign or zero extension.
- Detects misaligned accesses, and stalls the pipeline through mem_busy while a bus transaction is outstanding.

Parameters:
- XLEN, 32, datapath and address width; legal values are 32 and 64.
- REG_W, 5, destination register index width.
- STRB_W, XLEN/8, byte-enable width; derived, do not override.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- stall_m  in  1  hazard unit holds the M register
- flush_m  in  1  load a bubble into M on the next advance
- valid_e  in  1  E-stage instruction valid
- alu_result_e  in  XLEN  effective address or ALU result
- write_data_e  in  XLEN  store data, right-aligned
- rd_e  in  REG_W  destination register
- pc_plus_4_e  in  XLEN  link value
- mem_read_e  in  1  load
- mem_write_e  in  1  store
- mem_size_e  in  3  funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
- bus_req_valid  out  1  request valid
- bus_req_ready  in  1  request accepted
- bus_addr  out  XLEN  byte address (unaligned offset preserved)
- bus_wr_en  out  1  1 = write, 0 = read
- bus_wr_data  out  XLEN  lane-shifted store data
- bus_byte_en  out  STRB_W  active byte lanes
- bus_rsp_valid  in  1  response or write acknowledge
- bus_rd_data  in  XLEN  raw read word
- valid_m  out  1  M-stage instruction valid
- alu_result_m  out  XLEN  registered alu_result_e
- read_data_m  out  XLEN  extended load data
- rd_m  out  REG_W  registered rd_e
- pc_plus_4_m  out  XLEN  registered pc_plus_4_e
- misaligned_m  out  1  M-stage access is misaligned
- mem_busy  out  1  stall request to the hazard unit

Behaviour:
- Reset:
  - All M registers clear to 0, state = IDLE, hold register = 0.
  - valid_m, bus_req_valid, mem_busy and misaligned_m are all 0 during and after reset.
  - A reset mid-transaction abandons it; late bus_rsp_valid is ignored while in IDLE.
- Advance:
  - advance = !stall_m && !mem_busy. The M register loads only on advance; otherwise it holds.
  - On advance with flush_m = 1, valid_m is loaded as 0 and the memory controls as 0.
  - flush_m is ignored on non-advance cycles, so an issued transaction always completes.
- mem_op = valid_m && (mem_read_m || mem_write_m) && !misaligned_m.
- Misalignment:
  - H needs addr[0] = 0; W needs addr[1:0] = 0; D needs addr[2:0] = 0.
  - D, WU and LWU are illegal when XLEN=32 and are treated as W.
  - A misaligned access issues no bus request, misaligned_m = 1, and read_data_m = 0.
- FSM states: IDLE, REQ, RSP, DONE.
  - IDLE→REQ when advance loads a mem_op.
  - REQ: bus_req_valid = 1; on bus_req_ready go to RSP.
  - RSP: on bus_rsp_valid, latch bus_rd_data into hold and go to DONE.
  - DONE→IDLE on advance, or →REQ if advance loads a new mem_op.
  - IDLE and DONE re-enter REQ directly when a new mem_op loads.
- mem_busy = (state==REQ) || (state==RSP && !bus_rsp_valid). This is combinational, so a same-cycle response releases the stall.
- Latency:
  - A non-memory instruction spends 1 cycle in M.
  - A memory op with ready = 1 and the response on the next cycle spends 2 cycles in M.
- Request fields:
  - Fields are combinational from the M register and stay stable while bus_req_valid && !bus_req_ready.
  - bus_byte_en = size_mask << addr[log2(STRB_W)-1:0], with size_mask = 1, 3, F or FF for B/H/W/D.
  - bus_wr_data = write_data_m << (8*offset).
- Load formatting:
  - raw = (state==RSP && bus_rsp_valid) ? bus_rd_data : hold.
  - Shift raw right by 8*offset, truncate to the access size, then sign-extend (B/H/W) or zero-extend (BU/HU/WU).
- read_data_m is 0 for stores and non-memory instructions.
- A store completes on its acknowledge (bus_rsp_valid); the data is ignored.

Decomposition:
- mem_pkg holds:
  - mem_size_t enum of the funct3 encodings;
  - mem_state_t enum {IDLE, REQ, RSP, DONE};
  - functions byte_mask(size) and is_misaligned(addr, size).
- One sub-module, load_extend: combinational raw word, offset and size in; extended XLEN value out. It is instantiated once and unit-tested on its own.

Test Plan:
- ALU pass-through: valid_e=1, alu_result_e=0x1234, rd_e=7, no mem op → next cycle alu_result_m=0x1234, rd_m=7, mem_busy=0, no bus request.
- Signed byte load: LB at addr 0x103, bus_rd_data=0x80FF_FF00 one cycle after ready → bus_byte_en=1000, read_data_m=0xFFFF_FF80, mem_busy high for exactly 1 cycle.
- Halfword store: SH write_data_e=0xABCD at addr 0x202 → bus_byte_en=1100, bus_wr_data=0xABCD_0000, bus_wr_en=1.
- Backpressure: bus_req_ready held low for 3 cycles, then rsp 2 cycles later → address and data stable throughout, mem_busy=1 for 5 cycles, M register unchanged.
- Misaligned word: LW at addr 0x101 → misaligned_m=1, bus_req_valid never asserts, read_data_m=0, mem_busy=0.
- Reset and flush: reset asserted in RSP → state IDLE, late rsp ignored. flush_m with stall_m=0 → valid_m=0, with no bus activity.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the Memory stage: funct3 size encodings,
// controller states, and the lane mask / alignment rules derived from size.
package mem_pkg;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_D  = 3'b011,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101,
    SZ_WU = 3'b110
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP,
    DONE
  } mem_state_t;

  // log2 of the access width in bytes; D and WU collapse to W on a 32-bit datapath
  function automatic logic [1:0] size_log2(input logic [2:0] f3, input logic is64);
    logic [1:0] lg;
    case (f3)
      SZ_B, SZ_BU: lg = 2'd0;
      SZ_H, SZ_HU: lg = 2'd1;
      SZ_W, SZ_WU: lg = 2'd2;
      SZ_D:        lg = is64 ? 2'd3 : 2'd2;
      default:     lg = 2'd2;
    endcase
    return lg;
  endfunction

  function automatic logic [7:0] byte_mask(input logic [1:0] lg);
    logic [7:0] mask;
    case (lg)
      2'd0:    mask = 8'h01;
      2'd1:    mask = 8'h03;
      2'd2:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [1:0] lg);
    logic mis;
    case (lg)
      2'd0:    mis = 1'b0;
      2'd1:    mis = addr_lo[0];
      2'd2:    mis = |addr_lo[1:0];
      default: mis = |addr_lo[2:0];
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load formatter: moves the addressed bytes of a raw bus word down to bit 0,
// truncates to the access size and sign- or zero-extends to XLEN.
module load_extend
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]           raw,
  input  logic [$clog2(XLEN/8)-1:0] offset,
  input  logic [2:0]                size,
  output logic [XLEN-1:0]           ext
);

  logic [XLEN-1:0] shifted;
  logic [1:0]      lg;
  logic            uns;

  always_comb begin
    shifted = raw >> {offset, 3'b000};
    lg      = size_log2(size, XLEN == 64);
    uns     = size[2];
    case (lg)
      2'd0:    ext = uns ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
      2'd1:    ext = uns ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
      2'd2:    ext = uns ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
      default: ext = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline Memory stage: E->M register, valid/ready bus master for loads and
// stores with lane shifting, misalignment detection and a stall while busy.
//
// state | meaning
// IDLE  | no bus transaction for the instruction in M
// REQ   | request presented, waiting for bus_req_ready
// RSP   | request accepted, waiting for bus_rsp_valid
// DONE  | response captured in hold, waiting for M to advance
module mem_stage
  import mem_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_W  = 5,
  parameter int STRB_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_m,
  input  logic              flush_m,
  input  logic              valid_e,
  input  logic [XLEN-1:0]   alu_result_e,
  input  logic [XLEN-1:0]   write_data_e,
  input  logic [REG_W-1:0]  rd_e,
  input  logic [XLEN-1:0]   pc_plus_4_e,
  input  logic              mem_read_e,
  input  logic              mem_write_e,
  input  logic [2:0]        mem_size_e,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [XLEN-1:0]   bus_addr,
  output logic              bus_wr_en,
  output logic [XLEN-1:0]   bus_wr_data,
  output logic [STRB_W-1:0] bus_byte_en,
  input  logic              bus_rsp_valid,
  input  logic [XLEN-1:0]   bus_rd_data,
  output logic              valid_m,
  output logic [XLEN-1:0]   alu_result_m,
  output logic [XLEN-1:0]   read_data_m,
  output logic [REG_W-1:0]  rd_m,
  output logic [XLEN-1:0]   pc_plus_4_m,
  output logic              misaligned_m,
  output logic              mem_busy
);

  localparam int  OFF_W = $clog2(STRB_W);
  localparam logic IS64 = (XLEN == 64);

  mem_state_t      state;
  logic [XLEN-1:0] hold;
  logic [XLEN-1:0] write_data_m;
  logic            mem_read_m;
  logic            mem_write_m;
  logic [2:0]      mem_size_m;

  logic             advance;
  logic             load_mem_op;
  logic             mem_op_m;
  logic             load_op_m;
  logic [1:0]       lg_m;
  logic [OFF_W-1:0] offset_m;
  logic [XLEN-1:0]  raw;
  logic [XLEN-1:0]  ext_data;

  assign advance  = !stall_m && !mem_busy;
  assign mem_busy = (state == REQ) || (state == RSP && !bus_rsp_valid);

  // What the M register is about to receive, so the controller can go straight to REQ
  assign load_mem_op = valid_e && !flush_m && (mem_read_e || mem_write_e) &&
                       !is_misaligned(alu_result_e[2:0], size_log2(mem_size_e, IS64));

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_m      <= 1'b0;
      alu_result_m <= '0;
      write_data_m <= '0;
      rd_m         <= '0;
      pc_plus_4_m  <= '0;
      mem_read_m   <= 1'b0;
      mem_write_m  <= 1'b0;
      mem_size_m   <= '0;
    end else if (advance) begin
      valid_m      <= valid_e && !flush_m;
      alu_result_m <= alu_result_e;
      write_data_m <= write_data_e;
      rd_m         <= rd_e;
      pc_plus_4_m  <= pc_plus_4_e;
      mem_read_m   <= mem_read_e && !flush_m;
      mem_write_m  <= mem_write_e && !flush_m;
      mem_size_m   <= mem_size_e;
    end
  end

  assign lg_m         = size_log2(mem_size_m, IS64);
  assign offset_m     = alu_result_m[OFF_W-1:0];
  assign misaligned_m = valid_m && (mem_read_m || mem_write_m) &&
                        is_misaligned(alu_result_m[2:0], lg_m);
  assign mem_op_m     = valid_m && (mem_read_m || mem_write_m) && !misaligned_m;
  assign load_op_m    = mem_op_m && mem_read_m;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hold  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (advance) state <= load_mem_op ? REQ : IDLE;
        end
        REQ: begin
          if (bus_req_ready) state <= RSP;
        end
        RSP: begin
          if (bus_rsp_valid) begin
            hold <= bus_rd_data;
            // A same-cycle response lets M advance now, possibly into the next access
            if (advance) state <= load_mem_op ? REQ : IDLE;
            else         state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus_req_valid = (state == REQ);
  assign bus_addr      = alu_result_m;
  assign bus_wr_en     = mem_write_m;
  assign bus_wr_data   = write_data_m << {offset_m, 3'b000};
  assign bus_byte_en   = STRB_W'(byte_mask(lg_m)) << offset_m;

  assign raw = (state == RSP && bus_rsp_valid) ? bus_rd_data : hold;

  load_extend #(
    .XLEN (XLEN)
  ) u_load_extend (
    .raw    (raw),
    .offset (offset_m),
    .size   (mem_size_m),
    .ext    (ext_data)
  );

  assign read_data_m = load_op_m ? ext_data : '0;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage (XLEN=32): random instruction stream with random bus
// latencies and stalls checked cycle by cycle against an arithmetic model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset, stall_m, flush_m, valid_e;
  logic [31:0] alu_result_e, write_data_e, pc_plus_4_e;
  logic [4:0]  rd_e;
  logic        mem_read_e, mem_write_e;
  logic [2:0]  mem_size_e;
  logic        bus_req_valid, bus_req_ready, bus_wr_en, bus_rsp_valid;
  logic [31:0] bus_addr, bus_wr_data, bus_rd_data;
  logic [3:0]  bus_byte_en;
  logic        valid_m, misaligned_m, mem_busy;
  logic [31:0] alu_result_m, read_data_m, pc_plus_4_m;
  logic [4:0]  rd_m;

  logic [31:0] le_raw, le_ext;
  logic [1:0]  le_off;
  logic [2:0]  le_size;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_stage #(.XLEN(32), .REG_W(5)) dut (
    .clk(clk), .reset(reset), .stall_m(stall_m), .flush_m(flush_m),
    .valid_e(valid_e), .alu_result_e(alu_result_e), .write_data_e(write_data_e),
    .rd_e(rd_e), .pc_plus_4_e(pc_plus_4_e), .mem_read_e(mem_read_e),
    .mem_write_e(mem_write_e), .mem_size_e(mem_size_e),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_addr(bus_addr), .bus_wr_en(bus_wr_en), .bus_wr_data(bus_wr_data),
    .bus_byte_en(bus_byte_en), .bus_rsp_valid(bus_rsp_valid),
    .bus_rd_data(bus_rd_data), .valid_m(valid_m), .alu_result_m(alu_result_m),
    .read_data_m(read_data_m), .rd_m(rd_m), .pc_plus_4_m(pc_plus_4_m),
    .misaligned_m(misaligned_m), .mem_busy(mem_busy)
  );

  load_extend #(.XLEN(32)) u_ext (
    .raw(le_raw), .offset(le_off), .size(le_size), .ext(le_ext)
  );

  typedef struct {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic        flush;
    int          d_r;
    int          d_s;
    int          n_st;
    logic [31:0] rdw;
  } instr_t;

  instr_t prog[$];
  instr_t cur, bubble;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ext_model(input logic [31:0] w, input int off, input logic [2:0] f3);
    longint unsigned v, lim;
    int nb;
    nb  = nbytes(f3);
    lim = 64'd1 << (8 * nb);
    v   = {32'd0, w} >> (8 * off);
    v   = v % lim;
    if (!f3[2] && v >= lim / 2) v = v - lim;
    return v[31:0];
  endfunction

  function automatic logic [3:0] be_model(input int off, input logic [2:0] f3);
    logic [63:0] m;
    m = ((64'd1 << nbytes(f3)) - 64'd1) << off;
    return m[3:0];
  endfunction

  function automatic logic [31:0] wd_model(input logic [31:0] wd, input int off);
    logic [63:0] m;
    m = {32'd0, wd} << (8 * off);
    return m[31:0];
  endfunction

  function automatic instr_t mk(input logic v, input logic [31:0] a, input logic [31:0] wd,
                                input logic [4:0] r, input logic l, input logic s,
                                input logic [2:0] f3, input logic fl, input int dr,
                                input int ds, input int ns, input logic [31:0] rw);
    instr_t i;
    i.valid = v;  i.addr = a;   i.wdata = wd; i.pc4 = $urandom; i.rd = r;
    i.ld = l;     i.st = s;     i.f3 = f3;    i.flush = fl;
    i.d_r = dr;   i.d_s = ds;   i.n_st = ns;  i.rdw = rw;
    return i;
  endfunction

  function automatic instr_t rnd_instr();
    int op;
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
    op = $urandom_range(0, 2);
    return mk(($urandom_range(0, 7) != 0), a, $urandom, 5'($urandom), op == 1, op == 2,
              3'($urandom_range(0, 6)), ($urandom_range(0, 9) == 0),
              $urandom_range(0, 2), $urandom_range(0, 2),
              ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0, $urandom);
  endfunction

  task automatic drive_e(input instr_t i);
    valid_e      = i.valid;
    alu_result_e = i.addr;
    write_data_e = i.wdata;
    rd_e         = i.rd;
    pc_plus_4_e  = i.pc4;
    mem_read_e   = i.ld;
    mem_write_e  = i.st;
    mem_size_e   = i.f3;
    flush_m      = i.flush;
  endtask

  logic live, memacc, mis, is_mem;
  int   rsp_c, total, off;

  initial begin
    bubble = mk(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0, 0, 0, 0, 32'h0);
    reset = 1'b1;
    stall_m = 1'b0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rd_data = 32'h0;
    drive_e(mk(1'b1, 32'h40, 32'h0, 5'd3, 1'b1, 1'b0, 3'd2, 1'b0, 0, 0, 0, 32'h0));

    // stand-alone load formatter
    for (int i = 0; i < 60; i++) begin
      le_raw  = $urandom;
      le_off  = 2'($urandom);
      le_size = 3'($urandom_range(0, 6));
      #1;
      chk("load_extend", le_ext, ext_model(le_raw, int'(le_off), le_size));
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid_m", valid_m, 1'b0);
    chk("rst_req_valid", bus_req_valid, 1'b0);
    chk("rst_mem_busy", mem_busy, 1'b0);
    chk("rst_misaligned", misaligned_m, 1'b0);
    chk("rst_alu_result_m", alu_result_m, 32'h0);
    chk("rst_read_data_m", read_data_m, 32'h0);

    prog.push_back(mk(1'b1, 32'h1234, 32'h0, 5'd7, 1'b0, 1'b0, 3'd2, 1'b0, 0, 0, 0, 32'h0));
    prog.push_back(mk(1'b1, 32'h103, 32'h0, 5'd8, 1'b1, 1'b0, 3'd0, 1'b0, 0, 0, 0, 32'h80FF_FF00));
    prog.push_back(mk(1'b1, 32'h202, 32'hABCD, 5'd9, 1'b0, 1'b1, 3'd1, 1'b0, 0, 0, 0, 32'h0));
    prog.push_back(mk(1'b1, 32'h200, 32'h0, 5'd10, 1'b1, 1'b0, 3'd2, 1'b0, 3, 1, 1, 32'hCAFE_F00D));
    prog.push_back(mk(1'b1, 32'h101, 32'h0, 5'd11, 1'b1, 1'b0, 3'd2, 1'b0, 0, 0, 0, 32'h0));
    prog.push_back(mk(1'b1, 32'h300, 32'h0, 5'd12, 1'b1, 1'b0, 3'd2, 1'b1, 0, 0, 0, 32'h0));
    prog.push_back(mk(1'b1, 32'h101, 32'h0, 5'd13, 1'b1, 1'b0, 3'd4, 1'b0, 1, 0, 2, 32'h0000_8000));
    prog.push_back(mk(1'b1, 32'h106, 32'h0, 5'd14, 1'b1, 1'b0, 3'd5, 1'b0, 0, 2, 0, 32'h9ABC_0000));
    for (int i = 0; i < 150; i++) prog.push_back(rnd_instr());

    reset = 1'b0;
    drive_e(prog[0]);

    for (int k = 0; k < prog.size(); k++) begin
      cur    = prog[k];
      live   = cur.valid && !cur.flush;
      memacc = live && (cur.ld || cur.st);
      mis    = memacc && ((cur.addr % nbytes(cur.f3)) != 0);
      is_mem = memacc && !mis;
      rsp_c  = cur.d_r + 1 + cur.d_s;
      total  = (is_mem ? rsp_c + 1 : 1) + cur.n_st;
      off    = int'(cur.addr % 4);
      for (int c = 0; c < total; c++) begin
        @(negedge clk);
        if (c == 0) drive_e((k + 1 < prog.size()) ? prog[k + 1] : bubble);
        stall_m = (c == total - 1) ? 1'b0 :
                  (c >= total - 1 - cur.n_st) ? 1'b1 : 1'($urandom_range(0, 1));
        bus_req_ready = (is_mem && c <= cur.d_r) ? (c == cur.d_r) : 1'($urandom_range(0, 1));
        if (is_mem && c == rsp_c) begin
          bus_rsp_valid = 1'b1;
          bus_rd_data   = cur.rdw;
        end else begin
          bus_rsp_valid = (!is_mem || c > rsp_c) ? 1'($urandom_range(0, 1)) : 1'b0;
          bus_rd_data   = $urandom;
        end
        #1;
        chk("valid_m", valid_m, live);
        chk("alu_result_m", alu_result_m, cur.addr);
        chk("rd_m", rd_m, cur.rd);
        chk("pc_plus_4_m", pc_plus_4_m, cur.pc4);
        chk("misaligned_m", misaligned_m, mis);
        chk("mem_busy", mem_busy, is_mem && c < rsp_c);
        chk("bus_req_valid", bus_req_valid, is_mem && c <= cur.d_r);
        if (is_mem && c <= cur.d_r) begin
          chk("bus_addr", bus_addr, cur.addr);
          chk("bus_wr_en", bus_wr_en, cur.st);
          chk("bus_byte_en", bus_byte_en, be_model(off, cur.f3));
          if (cur.st) chk("bus_wr_data", bus_wr_data, wd_model(cur.wdata, off));
        end
        if (is_mem && cur.ld) begin
          if (c >= rsp_c) chk("read_data_m", read_data_m, ext_model(cur.rdw, off, cur.f3));
        end else begin
          chk("read_data_zero", read_data_m, 32'h0);
        end
      end
    end

    // reset while waiting for a response, then a late response
    @(negedge clk);
    stall_m = 1'b0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
    drive_e(mk(1'b1, 32'h40, 32'h0, 5'd3, 1'b1, 1'b0, 3'd2, 1'b0, 0, 0, 0, 32'h0));
    @(negedge clk);
    bus_req_ready = 1'b1;
    drive_e(bubble);
    #1;
    chk("rst_seq_req", bus_req_valid, 1'b1);
    @(negedge clk);
    bus_req_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_seq_rsp_busy", mem_busy, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    bus_rsp_valid = 1'b1;
    bus_rd_data = $urandom;
    #1;
    chk("rst_seq_valid_m", valid_m, 1'b0);
    chk("rst_seq_busy", mem_busy, 1'b0);
    chk("rst_seq_req_valid", bus_req_valid, 1'b0);
    chk("rst_seq_read_data", read_data_m, 32'h0);
    chk("rst_seq_alu_result", alu_result_m, 32'h0);
    @(negedge clk);
    bus_rsp_valid = 1'b0;
    #1;
    chk("late_rsp_req_valid", bus_req_valid, 1'b0);
    chk("late_rsp_busy", mem_busy, 1'b0);
    chk("late_rsp_valid_m", valid_m, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
